// File: rtl/crypt_pipe_ctrl_pkg.sv
// Shared constants and helpers for the permutation pipeline controller.
package crypt_pipe_pkg;

  localparam int KEY_BITS_PER_STAGE = 2;
  localparam int NUM_STAGES_DEF     = 8;

  // LSB position of a stage's {k3,k2} pair inside a block key.
  function automatic int key_lsb(input int stage);
    return stage * KEY_BITS_PER_STAGE;
  endfunction

endpackage

// File: rtl/crypt_pipe_ctrl_stage_slot.sv
// One pipeline slot: valid bit plus key shadow of the block held in this stage.
module crypt_stage_slot
  import crypt_pipe_pkg::*;
#(
  parameter int IDX   = 0,
  parameter int KEY_W = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          i_flush,
  input  logic                          i_up_valid,
  input  logic [KEY_W-1:0]              i_up_key,
  input  logic                          i_dn_adv,
  output logic                          o_adv,
  output logic                          o_en,
  output logic                          o_valid,
  output logic [KEY_W-1:0]              o_key,
  output logic [KEY_BITS_PER_STAGE-1:0] o_key_slice
);

  logic             r_v;
  logic [KEY_W-1:0] r_kq;

  // Slot can capture when upstream holds a block and this slot is empty or draining.
  assign o_adv       = i_up_valid & (~r_v | i_dn_adv);
  // Reset forces the enable low at once, even while the source keeps offering.
  assign o_en        = o_adv & ~i_flush & ~reset;
  assign o_valid     = r_v;
  assign o_key       = r_kq;
  assign o_key_slice = i_up_key[key_lsb(IDX) +: KEY_BITS_PER_STAGE];

  // Occupancy and key shadow update; flush clears valid but leaves the key shadow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_v  <= 1'b0;
      r_kq <= '0;
    end else if (i_flush) begin
      r_v <= 1'b0;
    end else if (o_en) begin
      r_v  <= 1'b1;
      r_kq <= i_up_key;
    end else if (r_v & i_dn_adv) begin
      r_v <= 1'b0;
    end
  end

endmodule

// File: rtl/crypt_pipe_ctrl.sv
// Sequencing controller for the pipelined permutation datapath: per-stage
// enables with bubble collapsing, output backpressure and key delivery.
module crypt_pipe_ctrl
  import crypt_pipe_pkg::*;
#(
  parameter int NUM_STAGES = NUM_STAGES_DEF,
  parameter int KEY_W      = 2 * NUM_STAGES,
  parameter int CNT_W      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [KEY_W-1:0]                  in_key,
  input  logic                              flush,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUM_STAGES-1:0]             stage_en,
  output logic [2*NUM_STAGES-1:0]           stage_key,
  output logic                              busy,
  output logic [$clog2(NUM_STAGES+1)-1:0]   occupancy,
  output logic [CNT_W-1:0]                  done_count
);

  localparam int OCC_W = $clog2(NUM_STAGES + 1);

  logic             w_up_valid [NUM_STAGES];
  logic [KEY_W-1:0] w_up_key   [NUM_STAGES];
  logic             w_dn_adv   [NUM_STAGES];
  logic             w_adv      [NUM_STAGES];
  logic             w_valid    [NUM_STAGES];
  logic [KEY_W-1:0] w_key      [NUM_STAGES];
  logic             w_unused_tail;
  logic [OCC_W-1:0] w_occ;
  logic [CNT_W-1:0] r_done;

  // The advance chain runs combinationally from out_ready back to in_ready.
  for (genvar i = 0; i < NUM_STAGES; i++) begin : g_slot
    if (i == 0) begin : g_head
      assign w_up_valid[i] = in_valid;
      assign w_up_key[i]   = in_key;
    end else begin : g_body
      assign w_up_valid[i] = w_valid[i-1];
      assign w_up_key[i]   = w_key[i-1];
    end

    if (i == NUM_STAGES - 1) begin : g_tail
      assign w_dn_adv[i] = out_ready;
    end else begin : g_mid
      assign w_dn_adv[i] = w_adv[i+1];
    end

    crypt_stage_slot #(
      .IDX   (i),
      .KEY_W (KEY_W)
    ) u_slot (
      .clk         (clk),
      .reset       (reset),
      .i_flush     (flush),
      .i_up_valid  (w_up_valid[i]),
      .i_up_key    (w_up_key[i]),
      .i_dn_adv    (w_dn_adv[i]),
      .o_adv       (w_adv[i]),
      .o_en        (stage_en[i]),
      .o_valid     (w_valid[i]),
      .o_key       (w_key[i]),
      .o_key_slice (stage_key[key_lsb(i) +: KEY_BITS_PER_STAGE])
    );
  end

  // Stage 0's raw advance and the last key shadow have no consumer.
  assign w_unused_tail = ^{w_adv[0], w_key[NUM_STAGES-1]};

  assign in_ready   = (~w_valid[0] | w_dn_adv[0]) & ~flush;
  assign out_valid  = w_valid[NUM_STAGES-1];
  assign occupancy  = w_occ;
  assign busy       = (w_occ != '0);
  assign done_count = r_done;

  // Population count of stage valid bits.
  always_comb begin
    w_occ = '0;
    for (int i = 0; i < NUM_STAGES; i++) begin
      w_occ = w_occ + OCC_W'(w_valid[i]);
    end
  end

  // Delivered-block counter; a flush cycle never counts as a delivery.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_done <= '0;
    end else if (out_valid & out_ready & ~flush) begin
      r_done <= r_done + 1'b1;
    end
  end

endmodule

// File: tb/tb_crypt_pipe_ctrl.sv
// Self-checking bench for crypt_pipe_ctrl (4 stages) with a block-movement reference model.
module tb_crypt_pipe_ctrl;

  localparam int N  = 4;
  localparam int KW = 2 * N;
  localparam int CW = 16;
  localparam int OW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          flush = 1'b0;
  logic          out_ready = 1'b0;
  logic [KW-1:0] in_key = '0;
  logic          in_ready, out_valid, busy;
  logic [N-1:0]  stage_en;
  logic [2*N-1:0] stage_key;
  logic [OW-1:0] occupancy;
  logic [CW-1:0] done_count;

  always #5 clk = ~clk;

  crypt_pipe_ctrl #(.NUM_STAGES(N), .KEY_W(KW), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_key     (in_key),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .stage_en   (stage_en),
    .stage_key  (stage_key),
    .busy       (busy),
    .occupancy  (occupancy),
    .done_count (done_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Model: each slot holds a block id (-1 = empty); keys are stored by id.
  int            m_slot [N];
  logic [KW-1:0] m_key [$];
  int            m_done;
  int            saved_done;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    foreach (m_slot[i]) m_slot[i] = -1;
  endtask

  // One clock cycle: drive inputs, predict by moving blocks into free slots
  // from the output end backwards, compare, then commit on the edge.
  task automatic step(input logic iv, input logic [KW-1:0] ik, input logic ordy, input logic fl);
    int            ns [N];
    logic [N-1:0]  en;
    logic          dlv;
    logic          rdy;
    int            occ;
    logic [KW-1:0] k;
    @(negedge clk);
    in_valid  = iv;
    in_key    = ik;
    out_ready = ordy;
    flush     = fl;
    #1;
    occ = 0;
    foreach (m_slot[i]) if (m_slot[i] >= 0) occ++;
    ns  = m_slot;
    en  = '0;
    dlv = 1'b0;
    rdy = 1'b0;
    if (fl) begin
      foreach (ns[i]) ns[i] = -1;
    end else begin
      if (ns[N-1] >= 0 && ordy) begin
        dlv     = 1'b1;
        ns[N-1] = -1;
      end
      for (int i = N - 2; i >= 0; i--) begin
        if (ns[i] >= 0 && ns[i+1] < 0) begin
          ns[i+1]  = ns[i];
          ns[i]    = -1;
          en[i+1]  = 1'b1;
        end
      end
      rdy = (ns[0] < 0);
      if (iv && rdy) begin
        m_key.push_back(ik);
        ns[0] = m_key.size() - 1;
        en[0] = 1'b1;
      end
    end
    chk("in_ready",   32'(in_ready),   32'(rdy));
    chk("out_valid",  32'(out_valid),  32'(m_slot[N-1] >= 0));
    chk("busy",       32'(busy),       32'(occ != 0));
    chk("occupancy",  32'(occupancy),  32'(occ));
    chk("done_count", 32'(done_count), 32'(m_done));
    chk("stage_en",   32'(stage_en),   32'(en));
    for (int i = 0; i < N; i++) begin
      if (en[i]) begin
        k = m_key[ns[i]];
        chk("stage_key", 32'(stage_key[2*i +: 2]), 32'(k[2*i +: 2]));
      end
    end
    @(posedge clk);
    m_slot = ns;
    if (dlv) m_done = (m_done + 1) % 65536;
  endtask

  task automatic drain();
    repeat (N + 1) step(1'b0, '0, 1'b1, 1'b0);
  endtask

  initial begin
    model_clear();
    m_done = 0;

    // Reset state
    #1;
    chk("rst_in_ready",  32'(in_ready),   32'd1);
    chk("rst_out_valid", 32'(out_valid),  32'd0);
    chk("rst_stage_en",  32'(stage_en),   32'd0);
    chk("rst_stage_key", 32'(stage_key),  32'd0);
    chk("rst_busy",      32'(busy),       32'd0);
    chk("rst_occ",       32'(occupancy),  32'd0);
    chk("rst_done",      32'(done_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Single block with key E4: slices 00,01,10,11 walk down the stages
    step(1'b1, 8'hE4, 1'b1, 1'b0);
    repeat (4) step(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("single_done", 32'(done_count), 32'd1);

    // Ten blocks back-to-back at full throughput
    repeat (10) step(1'b1, KW'($urandom), 1'b1, 1'b0);
    repeat (N) step(1'b0, '0, 1'b1, 1'b0);
    #1;
    chk("stream_done", 32'(done_count), 32'd11);

    // Backpressure: six offers, four accepted, then one-for-one exchange
    repeat (6) step(1'b1, KW'($urandom), 1'b0, 1'b0);
    #1;
    chk("bp_occ",      32'(occupancy), 32'd4);
    chk("bp_in_ready", 32'(in_ready),  32'd0);
    step(1'b1, KW'($urandom), 1'b1, 1'b0);
    #1;
    chk("bp_swap_occ", 32'(occupancy), 32'd4);
    drain();

    // Bubbles compact toward the output while stalled
    for (int c = 0; c < 12; c++) step(logic'(c % 2 == 0), KW'($urandom), 1'b0, 1'b0);
    #1;
    chk("bubble_occ", 32'(occupancy), 32'd4);
    drain();

    // Flush with three blocks in flight and a competing offer
    repeat (3) step(1'b1, KW'($urandom), 1'b0, 1'b0);
    #1;
    chk("pre_flush_occ", 32'(occupancy), 32'd3);
    saved_done = m_done;
    step(1'b1, KW'($urandom), 1'b1, 1'b1);
    #1;
    chk("flush_occ",  32'(occupancy),  32'd0);
    chk("flush_busy", 32'(busy),       32'd0);
    chk("flush_done", 32'(done_count), 32'(saved_done));

    // Randomized traffic with occasional flush
    for (int c = 0; c < 300; c++) begin
      step(logic'($urandom % 4 != 0), KW'($urandom), logic'($urandom % 3 != 0),
           logic'($urandom % 20 == 0));
    end

    // Reset mid-stream with two blocks in flight
    step(1'b0, '0, 1'b0, 1'b1);
    repeat (2) step(1'b1, KW'($urandom), 1'b0, 1'b0);
    #1;
    chk("pre_rst_occ", 32'(occupancy), 32'd2);
    @(negedge clk);
    in_valid  = 1'b1;
    in_key    = KW'($urandom);
    out_ready = 1'b1;
    flush     = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_stage_en",  32'(stage_en),  32'd0);
    chk("midrst_occ",       32'(occupancy), 32'd0);
    @(negedge clk);
    reset     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    model_clear();
    m_done = 0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready),   32'd1);
    chk("post_rst_done",     32'(done_count), 32'd0);
    repeat (3) step(1'b1, KW'($urandom), 1'b1, 1'b0);
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/crypt_pipe_ctrl.md
Name: crypt_pipe_ctrl

Overview:
- Sequencing controller for the pipelined permutation datapath. Each datapath stage has a per-stage Enable and a 2-bit key select, and holds four 32-bit words.
- Accepts blocks over a valid/ready handshake and tracks occupancy per stage. Generates per-stage enables with bubble collapsing and output backpressure.
- Delivers to each stage the key pair of the block that stage is capturing.
- Sits between the block source/sink and the chain of stage registers. The controller owns no data, only valid and key shadow state.

Parameters:
- NUM_STAGES, 8: number of datapath stages sequenced (>=2).
- KEY_W, 2*NUM_STAGES: per-block key width. Stage i uses bits [2i+1:2i], with k2 = bit 2i and k3 = bit 2i+1.
- CNT_W, 16: width of the completed-block counter.

Ports:
- clk, input, 1: clock.
- reset, input, 1: reset, asynchronous, active-high.
- in_valid, input, 1: source offers a block on stage-0 data inputs.
- in_ready, output, 1: controller accepts the block this cycle.
- in_key, input, KEY_W: key of the offered block.
- flush, input, 1: synchronous discard of all in-flight blocks.
- out_valid, output, 1: last stage holds a valid block.
- out_ready, input, 1: sink takes the last-stage block this cycle.
- stage_en, output, NUM_STAGES: Enable for stage i.
- stage_key, output, 2*NUM_STAGES: {k3,k2} for stage i at bits [2i+1:2i].
- busy, output, 1: any stage valid.
- occupancy, output, $clog2(NUM_STAGES+1): count of valid stages.
- done_count, output, CNT_W: blocks delivered (out_valid & out_ready), wraps.

Behaviour:
- State per stage i:
  - v[i]: valid bit.
  - kq[i]: KEY_W-bit key shadow of the block held in stage i.
- Reset: v=0, kq=0, done_count=0. All outputs derived from these give in_ready=1, out_valid=0, stage_en=0, stage_key=0, busy=0, occupancy=0.
- Advance terms, combinational:
  - adv[N-1] = v[N-2] & (~v[N-1] | out_ready).
  - adv[i] = v[i-1] & (~v[i] | adv[i+1]) for 0<i<N-1.
  - in_ready = ~v[0] | adv[1].
  - adv[0] = in_valid & in_ready.
  - The chain from out_ready to in_ready is combinational by design. There is no skid buffer.
- stage_en[i] = adv[i] & ~flush.
- stage_key slice i:
  - Stage 0: in_key[1:0].
  - Stage i>0: kq[i-1][2i+1:2i].
  - Valid in the same cycle as stage_en[i].
- On each clk edge, for each stage i:
  - If stage_en[i]: v[i]<=1 and kq[i]<=source key. The source key is in_key for i=0, otherwise kq[i-1].
  - Else if the block in stage i moved downstream (adv[i+1] for i<N-1, or out_valid&out_ready for i=N-1): v[i]<=0.
  - Else: hold.
- out_valid = v[N-1].
- Latency: a block accepted in cycle t gives out_valid in cycle t+NUM_STAGES, assuming no stall.
- Throughput: 1 block/cycle with out_ready held 1.
- Backpressure: with out_ready=0, blocks compact toward the last stage. in_ready drops only when every stage is valid.
- With full occupancy and out_ready=1, all stages advance in the same cycle and in_ready=1.
- Flush:
  - In the flush cycle, stage_en=0 and in_ready=0. An in_valid in that cycle is not accepted.
  - Next edge: all v<=0. kq is held.
  - done_count does not increment in the flush cycle, even if out_ready=1.
- done_count increments on out_valid & out_ready & ~flush and wraps at 2^CNT_W.
- occupancy is the popcount of v. busy = |v.
- Reset mid-operation clears all state immediately. stage_en goes to 0 asynchronously.

Decomposition:
- Package crypt_pipe_pkg holds:
  - KEY_BITS_PER_STAGE=2
  - default NUM_STAGES
  - a key-slice index function (stage -> LSB position)
- Sub-module crypt_stage_slot holds one v/kq pair, its next-state logic and its adv output, taking the upstream valid and the downstream adv as inputs.
- It is instantiated NUM_STAGES times via generate. Slot 0 is fed by in_valid/in_key.

Test Plan:
- NUM_STAGES=4, reset, then one block with in_key=8'hE4 accepted at cycle 0, out_ready=1:
  - stage_key slices are 2'b00, 2'b01, 2'b10, 2'b11 in cycles 0..3 with stage_en one-hot 1,2,4,8.
  - out_valid=1 in cycle 4; done_count goes 0->1.
- Streaming 10 blocks back-to-back, out_ready=1:
  - in_ready stays 1.
  - out_valid stays 1 in cycles 4..13.
  - Each output's shadow key matches its input order.
  - done_count=10.
- Hold out_ready=0 while offering 6 blocks:
  - 4 are accepted; in_ready=0 from cycle 4; occupancy=4.
  - Raising out_ready for 1 cycle gives one output and one acceptance in the same cycle; occupancy stays 4.
- Bubble pattern: in_valid alternating 1/0 with out_ready=0:
  - Blocks compact until occupancy=4.
  - No stage_en is asserted on an invalid upstream stage.
- flush with occupancy=3 and in_valid=1 in the same cycle:
  - stage_en=0 and in_ready=0 that cycle.
  - Next cycle occupancy=0, busy=0; done_count unchanged.
- Assert reset mid-stream with occupancy=2:
  - out_valid and stage_en go to 0 immediately.
  - After release, in_ready=1 and done_count=0.
